// File: rtl/sprite_linebuf_writer_pkg.sv
// Shared constants for the sprite scanline renderer and the line-buffer reader.
package sprite_linebuf_writer_pkg;

    localparam int unsigned DEF_XW     = 10;
    localparam int unsigned DEF_LINE_W = 512;
    localparam int unsigned DEF_SPW    = 16;
    localparam int unsigned DEF_BW     = 7;
    localparam int unsigned LENW       = 5;

    // Nibble code meaning "no pixel": reader and priority logic must agree on it
    localparam logic [3:0] TRANSP = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_pix_sel.sv
// Picks the current pixel nibble of a sprite row, honouring horizontal mirroring.
module sprite_pix_sel
    import sprite_linebuf_writer_pkg::*;
#(
    parameter int unsigned SPW = DEF_SPW
) (
    input  logic [4*SPW-1:0] pix,
    input  logic [LENW-1:0]  len,
    input  logic             hflip,
    input  logic [LENW-1:0]  idx,
    output logic [3:0]       nib_c
);

    logic [LENW-1:0] sel;

    // Indices beyond the row read as transparent
    always_comb begin
        sel   = hflip ? LENW'(len - idx - LENW'(1)) : idx;
        nib_c = TRANSP;
        for (int unsigned i = 0; i < SPW; i++) begin
            if (sel == LENW'(i)) begin
                nib_c = pix[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/sprite_linebuf_writer.sv
// Write-side engine of the scanline buffer: renders one sprite row per command with
// first-written-wins priority via read-modify-write on the buffer's write port.
module sprite_linebuf_writer
    import sprite_linebuf_writer_pkg::*;
#(
    parameter int unsigned XW     = DEF_XW,
    parameter int unsigned LINE_W = DEF_LINE_W,
    parameter int unsigned SPW    = DEF_SPW,
    parameter int unsigned BW     = DEF_BW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [XW:0]       cmd_x,
    input  logic [LENW-1:0]   cmd_len,
    input  logic              cmd_hflip,
    input  logic [BW-1:0]     cmd_bank,
    input  logic [4*SPW-1:0]  cmd_pix,
    output logic [XW-1:0]     lb_adr,
    output logic [BW+3:0]     lb_dat,
    output logic              lb_we,
    input  logic [BW+3:0]     lb_rdat,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic [XW:0]        x_q;
    logic [LENW-1:0]    len_q;
    logic               hflip_q;
    logic [BW-1:0]      bank_q;
    logic [4*SPW-1:0]   pix_q;
    logic [LENW-1:0]    idx_q, idx_d;
    logic               done_q, done_d;
    logic               load;

    logic [3:0]         nib;
    logic [XW+1:0]      px;
    logic               skip;
    logic               last;
    logic               rdat_unused;

    sprite_pix_sel #(.SPW(SPW)) u_pix_sel (
        .pix   (pix_q),
        .len   (len_q),
        .hflip (hflip_q),
        .idx   (idx_q),
        .nib_c (nib)
    );

    // Extra headroom bit so x + idx never wraps back onto the visible line
    assign px   = (XW+2)'(x_q) + (XW+2)'(idx_q);
    assign skip = (nib == TRANSP) || (px >= (XW+2)'(LINE_W));
    assign last = (idx_q + LENW'(1)) == len_q;

    assign busy        = (state_q != ST_IDLE);
    assign cmd_ready   = (state_q == ST_IDLE) && !abort;
    assign done        = done_q;
    assign rdat_unused = ^lb_rdat[BW+3:4];

    // Next-state and buffer-port decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        lb_adr  = px[XW-1:0];
        lb_dat  = {bank_q, nib};
        lb_we   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load  = 1'b1;
                    idx_d = '0;
                    if (cmd_len != '0) begin
                        state_d = ST_RD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (skip) begin
                    idx_d = idx_q + LENW'(1);
                    if (last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                lb_we = (lb_rdat[3:0] == TRANSP);
                idx_d = idx_q + LENW'(1);
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line start cancels everything, including a command offered this cycle
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
            load    = 1'b0;
            lb_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            x_q     <= '0;
            len_q   <= '0;
            hflip_q <= 1'b0;
            bank_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (load) begin
                x_q     <= cmd_x;
                len_q   <= cmd_len;
                hflip_q <= cmd_hflip;
                bank_q  <= cmd_bank;
                pix_q   <= cmd_pix;
            end
        end
    end

endmodule

// File: tb/tb_sprite_linebuf_writer.sv
// Scoreboard bench for sprite_linebuf_writer with a behavioural 1-cycle-latency line buffer.
module tb_sprite_linebuf_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x = '0;
    logic [4:0]  cmd_len = '0;
    logic        cmd_hflip = 1'b0;
    logic [6:0]  cmd_bank = '0;
    logic [63:0] cmd_pix = '0;
    logic [9:0]  lb_adr;
    logic [10:0] lb_dat;
    logic        lb_we;
    logic [10:0] lb_rdat;
    logic        busy;
    logic        done;

    sprite_linebuf_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_len   (cmd_len),
        .cmd_hflip (cmd_hflip),
        .cmd_bank  (cmd_bank),
        .cmd_pix   (cmd_pix),
        .lb_adr    (lb_adr),
        .lb_dat    (lb_dat),
        .lb_we     (lb_we),
        .lb_rdat   (lb_rdat),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural line buffer
    logic [10:0] mem [0:1023];
    logic        clr = 1'b0;
    logic        pre_en = 1'b0;
    logic [9:0]  pre_adr = '0;
    logic [10:0] pre_dat = '0;

    always @(posedge clk) begin
        lb_rdat <= mem[lb_adr];
        if (lb_we) mem[lb_adr] <= lb_dat;
        if (clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
        if (pre_en) mem[pre_adr] <= pre_dat;
    end

    // Scoreboard state
    logic [10:0] exp_mem [0:1023];
    logic [20:0] wq[$];
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit ignore_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lb_we && !ignore_wr) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'(wq.size()), 64'd1);
                end else begin
                    logic [20:0] e;
                    e = wq.pop_front();
                    chk("wr_adr", 64'(lb_adr), 64'(e[20:11]));
                    chk("wr_dat", 64'(lb_dat), 64'(e[10:0]));
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic model(input logic [10:0] x, input logic [4:0] len, input logic hf,
                         input logic [6:0] bank, input logic [63:0] pix, output int lat);
        lat = 1;
        for (int i = 0; i < int'(len); i++) begin
            int k;
            int px;
            logic [63:0] sh;
            logic [3:0] n;
            k  = hf ? (int'(len) - 1 - i) : i;
            sh = pix >> (4 * k);
            n  = sh[3:0];
            px = int'(x) + i;
            if (n == 4'h0 || px >= 512) begin
                lat += 1;
            end else begin
                lat += 2;
                if (exp_mem[px][3:0] == 4'h0) begin
                    wq.push_back({10'(px), bank, n});
                    exp_mem[px] = {bank, n};
                end
            end
        end
    endtask

    task automatic clear_buf(input bit pre, input logic [9:0] a, input logic [10:0] d);
        @(negedge clk);
        clr = 1'b1; pre_en = pre; pre_adr = a; pre_dat = d;
        @(negedge clk); #1;
        clr = 1'b0; pre_en = 1'b0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        if (pre) exp_mem[a] = d;
    endtask

    // Issue one command at the current cycle (or once ready) and wait for its done
    task automatic send(input string tag, input logic [10:0] x, input logic [4:0] len,
                        input logic hf, input logic [6:0] bank, input logic [63:0] pix,
                        output int meas);
        int lat, hs, tgt, n;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); #1; n++; end
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        model(x, len, hf, bank, pix, lat);
        cmd_x = x; cmd_len = len; cmd_hflip = hf; cmd_bank = bank; cmd_pix = pix;
        cmd_valid = 1'b1;
        hs  = cyc;
        tgt = done_cnt + 1;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (done_cnt < tgt && n < 400) begin @(negedge clk); #1; n++; end
        chk({tag, "_done"}, 64'(done_cnt), 64'(tgt));
        meas = done_cyc - hs;
        chk({tag, "_lat"}, 64'(meas), 64'(lat));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int m, dc;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_we",    64'(lb_we), 64'd0);
        chk("rst_adr",   64'(lb_adr), 64'd0);
        chk("rst_dat",   64'(lb_dat), 64'd0);
        clr = 1'b0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        rst_n = 1'b1;
        @(negedge clk); #1;

        send("t1", 11'd100, 5'd4, 1'b0, 7'd5, 64'h4321, m);
        chk("t1_lat9", 64'(m), 64'd9);
        chk("t1_m100", 64'(mem[100]), 64'h051);
        chk("t1_m103", 64'(mem[103]), 64'h054);

        clear_buf(1'b0, '0, '0);
        send("t2", 11'd100, 5'd4, 1'b1, 7'd5, 64'h4321, m);
        chk("t2_m100", 64'(mem[100]), 64'h054);
        chk("t2_m103", 64'(mem[103]), 64'h051);

        clear_buf(1'b1, 10'd101, 11'h023);
        send("t3", 11'd100, 5'd4, 1'b0, 7'd5, 64'h4321, m);
        chk("t3_m101", 64'(mem[101]), 64'h023);
        chk("t3_m102", 64'(mem[102]), 64'h053);

        clear_buf(1'b0, '0, '0);
        send("t4", 11'd508, 5'd4, 1'b0, 7'd5, 64'h0300, m);
        chk("t4_lat6", 64'(m), 64'd6);
        chk("t4_m510", 64'(mem[510]), 64'h053);

        send("t5", 11'h400, 5'd16, 1'b0, 7'd9, 64'h1111_1111_1111_1111, m);
        chk("t5_lat17", 64'(m), 64'd17);

        send("t6", 11'd50, 5'd0, 1'b0, 7'd1, 64'hF, m);
        chk("t6_lat1", 64'(m), 64'd1);

        // Back-to-back randomized rows over a filling buffer
        for (int t = 0; t < 24; t++) begin
            logic [10:0] rx;
            rx = 11'($urandom_range(600, 0));
            if ($urandom_range(7, 0) == 0) rx = rx | 11'h400;
            send("rnd", rx, 5'($urandom_range(16, 0)), 1'($urandom),
                 7'($urandom), {$urandom, $urandom} & {$urandom, $urandom}, m);
        end
        chk("rnd_drained", 64'(wq.size()), 64'd0);

        // Abort in the first WR cycle
        clear_buf(1'b0, '0, '0);
        dc = done_cnt;
        cmd_x = 11'd200; cmd_len = 5'd8; cmd_hflip = 1'b0; cmd_bank = 7'd3;
        cmd_pix = 64'h8765_4321; cmd_valid = 1'b1;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1; #1;
        chk("abort_we",    64'(lb_we), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd0);
        chk("abort_busy",  64'(busy), 64'd1);
        @(posedge clk); #1;
        abort = 1'b0; #1;
        chk("abort_idle",  64'(busy), 64'd0);
        chk("abort_rdy",   64'(cmd_ready), 64'd1);
        repeat (12) @(negedge clk);
        #1;
        chk("abort_nodone", 64'(done_cnt), 64'(dc));
        chk("abort_mem",    64'(mem[200]), 64'd0);

        // Abort with a command offered in IDLE: not accepted
        abort = 1'b1; cmd_valid = 1'b1; #1;
        chk("abort_idle_rdy", 64'(cmd_ready), 64'd0);
        @(negedge clk); #1;
        abort = 1'b0; cmd_valid = 1'b0; #1;
        chk("abort_idle_busy", 64'(busy), 64'd0);
        chk("abort_idle_q", 64'(wq.size()), 64'd0);

        // Asynchronous reset mid-command
        ignore_wr = 1'b1;
        cmd_x = 11'd300; cmd_len = 5'd8; cmd_hflip = 1'b1; cmd_bank = 7'h7F;
        cmd_pix = 64'hFEDC_BA98; cmd_valid = 1'b1;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        chk("rst2_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0; #1;
        chk("rst2_we",    64'(lb_we), 64'd0);
        chk("rst2_adr",   64'(lb_adr), 64'd0);
        chk("rst2_dat",   64'(lb_dat), 64'd0);
        chk("rst2_busy",  64'(busy), 64'd0);
        chk("rst2_done",  64'(done), 64'd0);
        chk("rst2_ready", 64'(cmd_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
